// File: rtl/cordic16_pkg.sv
// cordic16_pkg: shared widths, arctangent table and FSM state type for the cordic16 datapath.
`default_nettype none

package cordic16_pkg;

  localparam int WIDTH    = 16;
  localparam int ITER_MAX = 15;

  // atan(2^-i) in Q3.13; entry 0 sits in the least significant slice.
  localparam logic [ITER_MAX*WIDTH-1:0] ATAN_TABLE = {
    16'd0,   16'd1,   16'd2,   16'd4,    16'd8,    16'd16,   16'd32, 16'd64,
    16'd128, 16'd256, 16'd511, 16'd1019, 16'd2007, 16'd3798, 16'd6434
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] atan_lut(input logic [3:0] idx);
    if (int'(idx) >= ITER_MAX) begin
      return '0;
    end
    return ATAN_TABLE[int'(idx)*WIDTH +: WIDTH];
  endfunction

endpackage

`default_nettype wire

// File: rtl/cordic_ashr16.sv
// cordic_ashr16: 16-bit sign-filling arithmetic right shifter, four log stages (8/4/2/1).
`default_nettype none

module cordic_ashr16
  import cordic16_pkg::*;
(
  input  logic [WIDTH-1:0] i_data,
  input  logic [3:0]       i_shamt,
  output logic [WIDTH-1:0] o_data
);

  logic             w_sign;
  logic [WIDTH-1:0] w_s8;
  logic [WIDTH-1:0] w_s4;
  logic [WIDTH-1:0] w_s2;

  assign w_sign = i_data[WIDTH-1];
  assign w_s8   = i_shamt[3] ? {{8{w_sign}}, i_data[15:8]} : i_data;
  assign w_s4   = i_shamt[2] ? {{4{w_sign}}, w_s8[15:4]}   : w_s8;
  assign w_s2   = i_shamt[1] ? {{2{w_sign}}, w_s4[15:2]}   : w_s4;
  assign o_data = i_shamt[0] ? {w_sign, w_s2[15:1]}        : w_s2;

endmodule

`default_nettype wire

// File: rtl/cordic16_iter.sv
// cordic16_iter: iterative rotation-mode CORDIC, one micro-rotation per clock on a shared datapath.
`default_nettype none

module cordic16_iter
  import cordic16_pkg::*;
#(
  parameter int ITER = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] z_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic [WIDTH-1:0] z_out
);

  localparam logic [3:0] C_LAST = 4'(ITER - 1);

  state_t           r_state;
  logic [3:0]       r_iter;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_z;

  logic [WIDTH-1:0] w_x_sh;
  logic [WIDTH-1:0] w_y_sh;
  logic [WIDTH-1:0] w_atan;
  logic             w_neg;
  logic [WIDTH-1:0] w_x_next;
  logic [WIDTH-1:0] w_y_next;
  logic [WIDTH-1:0] w_z_next;

  cordic_ashr16 u_ashr_x (
    .i_data  (r_x),
    .i_shamt (r_iter),
    .o_data  (w_x_sh)
  );

  cordic_ashr16 u_ashr_y (
    .i_data  (r_y),
    .i_shamt (r_iter),
    .o_data  (w_y_sh)
  );

  // Negative residual angle rotates clockwise (d = -1).
  assign w_atan   = atan_lut(r_iter);
  assign w_neg    = r_z[WIDTH-1];
  assign w_x_next = w_neg ? (r_x + w_y_sh) : (r_x - w_y_sh);
  assign w_y_next = w_neg ? (r_y - w_x_sh) : (r_y + w_x_sh);
  assign w_z_next = w_neg ? (r_z + w_atan) : (r_z - w_atan);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_iter  <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_x     <= x_in;
            r_y     <= y_in;
            r_z     <= z_in;
            r_iter  <= '0;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_x    <= w_x_next;
          r_y    <= w_y_next;
          r_z    <= w_z_next;
          r_iter <= r_iter + 4'd1;
          if (r_iter == C_LAST) begin
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy  = (r_state == ST_RUN);
  assign done  = (r_state == ST_DONE);
  assign x_out = r_x;
  assign y_out = r_y;
  assign z_out = r_z;

endmodule

`default_nettype wire

// File: tb/tb_cordic16_iter.sv
// tb_cordic16_iter: directed table-driven bench for cordic16_iter plus multi-cycle corner sequences.
`default_nettype none

module tb_cordic16_iter;

  localparam int ITER = 14;

  typedef struct {
    int x;
    int y;
    int z;
    int ex;
    int ey;
    int tol;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] x_in;
  logic [15:0] y_in;
  logic [15:0] z_in;
  logic        busy;
  logic        done;
  logic [15:0] x_out;
  logic [15:0] y_out;
  logic [15:0] z_out;

  int n_cmp;
  int n_fail;

  int ATAN_TB [15] = '{6434, 3798, 2007, 1019, 511, 256, 128, 64, 32, 16, 8, 4, 2, 1, 0};

  cordic16_iter #(.ITER(ITER)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .x_in  (x_in),
    .y_in  (y_in),
    .z_in  (z_in),
    .busy  (busy),
    .done  (done),
    .x_out (x_out),
    .y_out (y_out),
    .z_out (z_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic check_tol(input string name, input logic [15:0] act, input int exp, input int tol);
    int a;
    a = int'($signed(act));
    n_cmp++;
    if (a < exp - tol || a > exp + tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d +/- %0d", name, a, exp, tol);
    end
  endtask

  // Bit-exact reference of the rotation recurrence, on 16-bit wrapping arithmetic.
  function automatic void model(input int xi, input int yi, input int zi,
                                output int xo, output int yo, output int zo);
    logic signed [15:0] x, y, z, xn, yn;
    x = 16'(xi);
    y = 16'(yi);
    z = 16'(zi);
    for (int i = 0; i < ITER; i++) begin
      if (z >= 0) begin
        xn = x - (y >>> i);
        yn = y + (x >>> i);
        z  = z - 16'(ATAN_TB[i]);
      end else begin
        xn = x + (y >>> i);
        yn = y - (x >>> i);
        z  = z + 16'(ATAN_TB[i]);
      end
      x = xn;
      y = yn;
    end
    xo = int'(x);
    yo = int'(y);
    zo = int'(z);
  endfunction

  task automatic do_start(input int x, input int y, input int z);
    @(negedge clk);
    x_in  = 16'(x);
    y_in  = 16'(y);
    z_in  = 16'(z);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Edges counted inclusive of the start-sampling edge.
  task automatic wait_done(output int edges, output bit seen);
    edges = 1;
    seen  = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge clk);
      #1;
      edges++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic check_model(input string tag, input int x, input int y, input int z);
    int mx, my, mz;
    model(x, y, z, mx, my, mz);
    check_eq({tag, "_x_exact"}, int'($signed(x_out)), mx);
    check_eq({tag, "_y_exact"}, int'($signed(y_out)), my);
    check_eq({tag, "_z_exact"}, int'($signed(z_out)), mz);
  endtask

  initial begin
    vec_t vecs [6];
    int   edges;
    bit   seen;
    int   ndone;
    int   cx, cy, cz;
    int   last_done;
    int   bad_gap;
    int   bad_busy;
    string tag;

    n_cmp  = 0;
    n_fail = 0;
    vecs[0] = '{x: 9950,  y: 0,    z: 0,      ex: 16384,  ey: 0,      tol: 8};
    vecs[1] = '{x: 9950,  y: 0,    z: 6434,   ex: 11585,  ey: 11585,  tol: 8};
    vecs[2] = '{x: 9950,  y: 0,    z: -6434,  ex: 11585,  ey: -11585, tol: 8};
    vecs[3] = '{x: -9950, y: 0,    z: 0,      ex: -16384, ey: 0,      tol: 8};
    vecs[4] = '{x: 9950,  y: 0,    z: 12868,  ex: 0,      ey: 16384,  tol: 12};
    vecs[5] = '{x: 0,     y: 9950, z: 0,      ex: 0,      ey: 16384,  tol: 8};

    reset = 1'b1;
    start = 1'b0;
    x_in  = '0;
    y_in  = '0;
    z_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_x", int'(x_out), 0);
    check_eq("rst_y", int'(y_out), 0);
    check_eq("rst_z", int'(z_out), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      tag = $sformatf("vec%0d", v);
      do_start(vecs[v].x, vecs[v].y, vecs[v].z);
      check_eq({tag, "_busy"}, int'(busy), 1);
      wait_done(edges, seen);
      check_eq({tag, "_seen"}, int'(seen), 1);
      check_eq({tag, "_lat"}, edges, ITER + 1);
      check_eq({tag, "_excl"}, int'(busy & done), 0);
      check_tol({tag, "_x"}, x_out, vecs[v].ex, vecs[v].tol);
      check_tol({tag, "_y"}, y_out, vecs[v].ey, vecs[v].tol);
      check_tol({tag, "_z"}, z_out, 0, 4);
      check_model(tag, vecs[v].x, vecs[v].y, vecs[v].z);
      @(posedge clk);
      #1;
      check_eq({tag, "_done_pulse"}, int'(done), 0);
    end

    // start re-pulsed mid-run with different operands must be ignored
    do_start(9950, 0, 6434);
    ndone = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      start = (k == 3 || k == 7);
      if (start) begin
        x_in = 16'(-9950);
        y_in = 16'(3000);
        z_in = 16'(-4000);
      end
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    start = 1'b0;
    check_eq("busyprot_ndone", ndone, 1);
    check_model("busyprot", 9950, 0, 6434);

    // start held high: one operation every ITER+1 cycles
    @(negedge clk);
    x_in  = 16'(9950);
    y_in  = 16'(0);
    z_in  = 16'(0);
    start = 1'b1;
    ndone = 0;
    last_done = 0;
    bad_gap   = 0;
    bad_busy  = 0;
    for (int k = 0; k < 48; k++) begin
      @(posedge clk);
      #1;
      if (busy == done) bad_busy++;
      if (done) begin
        if (k - last_done != ((ndone == 0) ? ITER : ITER + 1)) bad_gap++;
        last_done = k;
        ndone++;
      end
    end
    @(negedge clk);
    start = 1'b0;
    check_eq("b2b_ndone", ndone, 3);
    check_eq("b2b_gap", bad_gap, 0);
    check_eq("b2b_busy", bad_busy, 0);
    repeat (20) @(posedge clk);

    // reset abandons a run at iteration 5
    do_start(9950, 0, 6434);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_busy", int'(busy), 0);
    check_eq("midrst_done", int'(done), 0);
    check_eq("midrst_x", int'(x_out), 0);
    check_eq("midrst_y", int'(y_out), 0);
    check_eq("midrst_z", int'(z_out), 0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check_eq("midrst_nodone", ndone, 0);
    do_start(9950, 0, -6434);
    wait_done(edges, seen);
    check_eq("postrst_lat", edges, ITER + 1);
    check_tol("postrst_x", x_out, 11585, 8);
    check_tol("postrst_y", y_out, -11585, 8);
    check_model("postrst", 9950, 0, -6434);

    // reset and start on the same edge: reset wins
    @(negedge clk);
    x_in  = 16'(1234);
    start = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rststart_busy", int'(busy), 0);
    check_eq("rststart_x", int'(x_out), 0);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rststart_idle", int'(busy), 0);

    cx = 0; cy = 0; cz = 0;
    model(0, 0, 0, cx, cy, cz);
    check_eq("model_zero_sanity", cx + cy, int'($signed(x_out)) + int'($signed(y_out)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, want finish before 500000");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/cordic16_iter.md
# cordic16_iter

Iterative 16-bit CORDIC rotation-mode engine for the cordic16 datapath. It accepts a start request with an initial vector and angle, then runs one micro-rotation per clock. Each micro-rotation uses a sign-filling arithmetic right shift by the iteration index, plus add/subtract and arctangent-table subtraction. It reports completion with a one-cycle done pulse. It reuses a single shift/add datapath for all iterations instead of unrolling one stage per iteration.

## Interface

Parameters:
- ITER, 14: number of micro-rotations. Legal range 1..15, because the shift amount is 4 bits.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled on clk edge
- x_in  in  16  initial x, two's complement Q2.14
- y_in  in  16  initial y, Q2.14
- z_in  in  16  initial angle, radians Q3.13 (8192 = 1.0); legal range ±12868 (±π/2)
- busy  out  1  high while iterating
- done  out  1  one-cycle pulse; results valid
- x_out  out  16  rotated x, Q2.14
- y_out  out  16  rotated y, Q2.14
- z_out  out  16  residual angle, Q3.13

## Operation

- States:
  - IDLE: waiting for a request.
  - RUN: iterating.
  - DONE: signalling completion.
- IDLE/DONE + start=1:
  - load x_in/y_in/z_in into the working registers.
  - iter ← 0.
  - go to RUN.
- IDLE + start=0: stay in IDLE.
- DONE + start=0: go to IDLE.
- RUN, per edge, with d = +1 if z[15]==0, else −1:
  - x ← x − d·(y >>> iter)
  - y ← y + d·(x >>> iter)
  - z ← z − d·ATAN[iter]
  - All three updates use the pre-edge values.
  - iter ← iter+1.
  - If iter==ITER−1, go to DONE.
- start is ignored in RUN. It is not queued.
- `>>>` is an arithmetic right shift: vacated MSBs take the sign bit, bits shifted off the LSB end are dropped, and a shift of 0 passes the value through.
- Arithmetic is modulo 2^16. There is no saturation and no rounding; overflow wraps.
- Gain is not compensated (K ≈ 1.6468). Callers prescale x_in/y_in by 1/K; 9950 represents 1/K.
- ATAN table, Q3.13, index 0..14: 6434, 3798, 2007, 1019, 511, 256, 128, 64, 32, 16, 8, 4, 2, 1, 0.
- x_out/y_out/z_out are driven directly from the working registers. They are stable from the DONE cycle until the next accepted start.
- reset: forces IDLE, iter=0, all working registers 0, busy=0, done=0. This applies in any state; a run in progress is abandoned and no done is produced.
- Output values under reset: busy=0, done=0, x_out=0, y_out=0, z_out=0.

## Timing

- Start sampled at edge T0 → busy=1 after T0.
- Iterations complete on edges T1..T_ITER.
- After T_ITER: busy=0, done=1 for exactly one cycle.
- Latency: ITER+1 edges from the start sample to the done edge.
- Back-to-back: start=1 during the done cycle is accepted at that edge. Throughput is one operation per ITER+1 cycles.
- busy and done are never high simultaneously.
- Reset asserted on the same edge as start: reset wins.

## Structure

- Package cordic16_pkg holds:
  - WIDTH=16
  - ITER_MAX=15
  - the ATAN table constant (15 entries × 16 bits)
  - the state typedef (enum IDLE/RUN/DONE)
- Sub-module cordic_ashr16: a 16-bit arithmetic right shifter built as four conditional stages (shift by 8, 4, 2, 1), each stage sign-filling. Inputs are data and a 4-bit shift amount. It is instantiated twice, once for x and once for y.
- The top module contains:
  - the FSM
  - the iteration counter
  - the x/y/z registers
  - three 16-bit add/subtract units
  - the table lookup

## Test plan

- **Zero angle:** x_in=9950, y_in=0, z_in=0, start → done exactly 15 edges after the start sample; x_out=16384±8, y_out=0±8, |z_out|≤4.
- **+π/4:** x_in=9950, y_in=0, z_in=6434 → x_out≈y_out≈11585±8. **−π/4:** z_in=−6434 → x_out≈11585, y_out≈−11585, each ±8.
- **Negative vector (sign fill through every shift stage):** x_in=−9950, y_in=0, z_in=0 → x_out=−16384±8, y_out=0±8.
- **Busy protection:** start re-pulsed at cycles 3 and 7 with different inputs → the outputs equal the first operation's results and only one done pulse occurs.
- **Back-to-back:** start held high continuously → done pulses every 15 cycles and busy=0 only during the done cycles.
- **Reset mid-run:** reset asserted at iteration 5 → the next cycle shows busy=0, done=0 and all outputs 0; no done follows; a fresh start afterwards produces correct results.
